// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and UART line bundle between two byte sources and the
// shared transmit arbiter.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       io_uart_txd;
    logic       tx_busy;
    logic       grant_id;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, io_uart_txd, tx_busy, grant_id
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, io_uart_txd, tx_busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1/8N2 UART transmit line between two
// byte-stream requesters; bytes are serialised LSB first from a register.
module uart_tx_arbiter #(
    parameter int CLK_DIV   = 104,
    parameter int STOP_BITS = 1
) (
    input  logic              io_mainClk,
    input  logic              io_asyncReset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [DIV_W-1:0] div_r;
    logic [2:0]       bit_idx_r;
    logic             stop_idx_r;
    logic [7:0]       shift_r;
    logic             txd_r;
    logic             busy_r;
    logic             grant_r;
    logic             sel0_s;
    logic             sel1_s;
    logic             accept_s;
    logic             bit_end_s;
    logic             last_stop_s;

    assign bit_end_s   = (div_r == DIV_LAST);
    assign last_stop_s = (STOP_BITS == 2) ? stop_idx_r : 1'b1;
    assign accept_s    = sel0_s | sel1_s;

    // Requester selection; readies are gated by reset so no handshake can
    // complete while the block is held in reset.
    always_comb begin
        sel0_s = 1'b0;
        sel1_s = 1'b0;
        if ((state_r == IDLE) && !io_asyncReset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (grant_r) begin
                    sel0_s = 1'b1;
                end else begin
                    sel1_s = 1'b1;
                end
            end else if (bus.req0_valid) begin
                sel0_s = 1'b1;
            end else if (bus.req1_valid) begin
                sel1_s = 1'b1;
            end else begin
                sel0_s = 1'b0;
                sel1_s = 1'b0;
            end
        end else begin
            sel0_s = 1'b0;
            sel1_s = 1'b0;
        end
    end

    // Frame sequencing: start bit, eight data bits, then STOP_BITS stop bits.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                if (bit_end_s && last_stop_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: divider, bit index, shift register and the registered line.
    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            div_r      <= '0;
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            shift_r    <= 8'h00;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            grant_r    <= 1'b1;
        end else begin
            busy_r <= (state_next_s != IDLE);
            case (state_r)
                IDLE: begin
                    div_r      <= '0;
                    bit_idx_r  <= 3'd0;
                    stop_idx_r <= 1'b0;
                    if (accept_s) begin
                        shift_r <= sel0_s ? bus.req0_data : bus.req1_data;
                        grant_r <= sel1_s;
                        txd_r   <= 1'b0;
                    end else begin
                        txd_r   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        div_r   <= '0;
                        txd_r   <= shift_r[0];
                        shift_r <= {1'b0, shift_r[7:1]};
                    end else begin
                        div_r   <= div_r + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        div_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            txd_r     <= 1'b1;
                            bit_idx_r <= 3'd0;
                        end else begin
                            txd_r     <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        div_r      <= '0;
                        txd_r      <= 1'b1;
                        stop_idx_r <= ~stop_idx_r;
                    end else begin
                        div_r      <= div_r + DIV_W'(1);
                    end
                end
                default: begin
                    div_r      <= '0;
                    bit_idx_r  <= 3'd0;
                    stop_idx_r <= 1'b0;
                    txd_r      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req0_ready  = sel0_s;
    assign bus.req1_ready  = sel1_s;
    assign bus.io_uart_txd = txd_r;
    assign bus.tx_busy     = busy_r;
    assign bus.grant_id    = grant_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (one and two stop bits) driven by
// queued requesters and compared each cycle against a frame-level model.
module tb_uart_tx_arbiter;
    localparam int DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       val0 [2];
    logic       val1 [2];
    logic [7:0] dat0 [2];
    logic [7:0] dat1 [2];

    uart_tx_arbiter_if bus_a ();
    uart_tx_arbiter_if bus_b ();

    assign bus_a.req0_valid = val0[0];
    assign bus_a.req0_data  = dat0[0];
    assign bus_a.req1_valid = val1[0];
    assign bus_a.req1_data  = dat1[0];
    assign bus_b.req0_valid = val0[1];
    assign bus_b.req0_data  = dat0[1];
    assign bus_b.req1_valid = val1[1];
    assign bus_b.req1_data  = dat1[1];

    uart_tx_arbiter #(.CLK_DIV(DIV), .STOP_BITS(1)) dut_a (
        .io_mainClk(clk), .io_asyncReset(rst), .bus(bus_a)
    );
    uart_tx_arbiter #(.CLK_DIV(DIV), .STOP_BITS(2)) dut_b (
        .io_mainClk(clk), .io_asyncReset(rst), .bus(bus_b)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    bit         withhold_en = 1'b0;
    int         sbits [2] = '{1, 2};
    int         off   [2];
    logic [7:0] fbyte [2];
    logic       last  [2];
    logic       hs0   [2];
    logic       hs1   [2];
    int         busy_cnt [2];
    logic [7:0] rq [4][$];
    int         acc_cyc [2][$];
    int         acc_who [2][$];

    // {req0_ready, req1_ready, io_uart_txd, tx_busy, grant_id}
    function automatic logic [4:0] obs(input int d);
        if (d == 0)
            return {bus_a.req0_ready, bus_a.req1_ready, bus_a.io_uart_txd, bus_a.tx_busy, bus_a.grant_id};
        else
            return {bus_b.req0_ready, bus_b.req1_ready, bus_b.io_uart_txd, bus_b.tx_busy, bus_b.grant_id};
    endfunction

    // Line level o cycles after the accept edge for byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int o);
        int k;
        k = o / DIV;
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
        else return 1'b1;
    endfunction

    task automatic check(input string tag, input int d, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, d, cyc, observed, expected);
        end
    endtask

    task automatic model_step(input int d);
        logic [4:0] o;
        logic [4:0] e;
        int         sel;
        o = obs(d);
        hs0[d] = o[4] & val0[d];
        hs1[d] = o[3] & val1[d];
        if (o[1]) busy_cnt[d]++;
        if (hs0[d]) begin acc_cyc[d].push_back(cyc); acc_who[d].push_back(0); end
        if (hs1[d]) begin acc_cyc[d].push_back(cyc); acc_who[d].push_back(1); end
        if (rst) begin
            e = 5'b00101;
            off[d]  = -1;
            last[d] = 1'b1;
        end else if (off[d] >= 0) begin
            e = {2'b00, frame_bit(fbyte[d], off[d]), 1'b1, last[d]};
            off[d]++;
            if (off[d] == (9 + sbits[d]) * DIV) off[d] = -1;
        end else begin
            sel = -1;
            if (val0[d] && val1[d]) sel = last[d] ? 0 : 1;
            else if (val0[d]) sel = 0;
            else if (val1[d]) sel = 1;
            e = {(sel == 0), (sel == 1), 1'b1, 1'b0, last[d]};
            if (sel >= 0) begin
                fbyte[d] = (sel == 0) ? dat0[d] : dat1[d];
                last[d]  = (sel == 1);
                off[d]   = 0;
            end
        end
        check("cycle_outputs", d, 32'(o), 32'(e));
    endtask

    task automatic drive(input int d);
        for (int r = 0; r < 2; r++) begin
            int   idx;
            logic hs;
            logic v;
            idx = d * 2 + r;
            hs  = (r == 0) ? hs0[d] : hs1[d];
            if (hs && rq[idx].size() > 0) void'(rq[idx].pop_front());
            v = (rq[idx].size() > 0) && !(withhold_en && ($urandom_range(0, 3) == 0));
            if (r == 0) begin
                val0[d] = v;
                dat0[d] = v ? rq[idx][0] : 8'($urandom);
            end else begin
                val1[d] = v;
                dat1[d] = v ? rq[idx][0] : 8'($urandom);
            end
        end
        hs0[d] = 1'b0;
        hs1[d] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            model_step(0);
            model_step(1);
            @(posedge clk);
            #1;
            cyc++;
            drive(0);
            drive(1);
        end
    endtask

    // mode 0/1: every accept from that requester; mode 2: alternating from req0.
    task automatic check_accepts(input string tag, input int n_exp, input int mode);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_count"}, d, 32'(acc_cyc[d].size()), 32'(n_exp));
            for (int i = 0; i < acc_cyc[d].size(); i++) begin
                check({tag, "_who"}, d, 32'(acc_who[d][i]), 32'((mode == 2) ? (i % 2) : mode));
                if (i > 0)
                    check({tag, "_spacing"}, d, 32'(acc_cyc[d][i] - acc_cyc[d][i-1]),
                          32'((9 + sbits[d]) * DIV + 1));
            end
            acc_cyc[d].delete();
            acc_who[d].delete();
        end
    endtask

    task automatic push_both(input int r, input logic [7:0] b);
        rq[r].push_back(b);
        rq[2 + r].push_back(b);
    endtask

    initial begin
        logic [4:0] o;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            val0[d] = 1'b0; val1[d] = 1'b0; dat0[d] = 8'h00; dat1[d] = 8'h00;
            off[d] = -1; last[d] = 1'b1; hs0[d] = 1'b0; hs1[d] = 1'b0; busy_cnt[d] = 0;
        end
        #1;
        for (int d = 0; d < 2; d++) check("reset_values", d, 32'(obs(d)), 32'h05);
        val0[0] = 1'b1; val1[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            o = obs(d);
            check("ready_in_reset", d, 32'(o[4:3]), 32'h0);
        end
        drive(0); drive(1);
        run(3);
        rst = 1'b0;

        // Single byte: 0x55 on the one-stop instance, 0x80 on the two-stop one.
        rq[0].push_back(8'h55);
        rq[2].push_back(8'h80);
        busy_cnt[0] = 0; busy_cnt[1] = 0;
        drive(0); drive(1);
        run(60);
        check("busy_len", 0, 32'(busy_cnt[0]), 32'd40);
        check("busy_len", 1, 32'(busy_cnt[1]), 32'd44);
        check_accepts("single", 1, 0);

        // Contention from reset: strict alternation starting with req0.
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_both(0, 8'hA1);
            push_both(1, 8'hB2);
        end
        drive(0); drive(1);
        run(6 * 45 + 10);
        check_accepts("alternate", 6, 2);

        // req1 streaming alone.
        for (int i = 0; i < 4; i++) push_both(1, 8'(i));
        drive(0); drive(1);
        run(4 * 45 + 10);
        check_accepts("stream1", 4, 1);

        // Reset in the middle of a 0xFF frame.
        push_both(0, 8'hFF);
        drive(0); drive(1);
        run(21);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check("reset_midframe", d, 32'(obs(d)), 32'h05);
        for (int d = 0; d < 2; d++) begin acc_cyc[d].delete(); acc_who[d].delete(); end
        push_both(0, 8'hA1);
        push_both(1, 8'hB2);
        drive(0); drive(1);
        run(2);
        rst = 1'b0;
        run(50);
        for (int d = 0; d < 2; d++)
            check("post_reset_first", d, 32'((acc_who[d].size() > 0) ? acc_who[d][0] : 99), 32'd0);
        run(60);
        for (int d = 0; d < 2; d++) begin acc_cyc[d].delete(); acc_who[d].delete(); end

        // Data changes after acceptance must not alter the frame in flight.
        push_both(0, 8'h3C);
        push_both(0, 8'hC3);
        drive(0); drive(1);
        run(2 * 45 + 10);
        check_accepts("hold_data", 2, 0);

        // Randomised traffic with valid withdrawal and one reset pulse.
        withhold_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) push_both($urandom_range(0, 1), 8'($urandom));
            if (it == 20) begin
                rst = 1'b1;
                run(1);
                rst = 1'b0;
            end
            run(30);
        end
        withhold_en = 1'b0;
        drive(0); drive(1);
        run(1000);
        for (int i = 0; i < 4; i++) check("drained", i / 2, 32'(rq[i].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one 8N1/8N2 UART transmit line between two byte-stream requesters, for example the Murax SoC console and a board-level status/debug reporter. The block arbitrates round-robin, accepts one byte per frame on a valid/ready handshake and serialises it LSB-first onto io_uart_txd. It sits in the board toplevel between the requesters and the io_uart_txd pin.

Parameters:
CLK_DIV, 104, io_mainClk cycles per UART bit; legal range >= 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
io_mainClk  input  1  single system clock; all logic is rising-edge.
io_asyncReset  input  1  asynchronous, active-high reset.
req0_valid  input  1  requester 0 has a byte pending.
req0_data  input  8  requester 0 byte.
req0_ready  output  1  requester 0 byte accepted this cycle.
req1_valid  input  1  requester 1 has a byte pending.
req1_data  input  8  requester 1 byte.
req1_ready  output  1  requester 1 byte accepted this cycle.
io_uart_txd  output  1  serial output; idle level is high.
tx_busy  output  1  frame in progress.
grant_id  output  1  index of the last granted requester.

Behaviour:
- Reset values (applied asynchronously):
  - io_uart_txd = 1, tx_busy = 0, req0_ready = req1_ready = 0.
  - grant_id = 1, so req0 wins the first contention.
  - State = IDLE, bit counter and divider = 0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - readyN is combinational: it is high only in IDLE, only for the selected requester, and only when that requester's validN is high.
  - Selection when only one requester is valid: that requester.
  - Selection when both are valid: the requester != grant_id.
  - At most one ready is high in any cycle.
- Transfer occurs on a rising edge where validN and readyN are both high. On that edge:
  - data is latched into the shift register;
  - grant_id <= N;
  - state moves to START.
- START: io_uart_txd = 0 for exactly CLK_DIV cycles, then DATA.
- DATA: 8 bits, LSB first, CLK_DIV cycles per bit. A 3-bit index wraps 7 -> STOP.
- STOP: io_uart_txd = 1 for STOP_BITS*CLK_DIV cycles, then IDLE.
- io_uart_txd is driven from a register, so there are no glitches. It is 1 in IDLE.
- tx_busy = 1 in START, DATA and STOP; it is 0 in IDLE.
- Latency and throughput:
  - The first start-bit cycle is the cycle after the accept edge.
  - The earliest next accept is in the IDLE cycle following the last stop cycle.
  - Back-to-back period is (9+STOP_BITS)*CLK_DIV + 1 cycles per byte.
- Divider: a counter of width $clog2(CLK_DIV). It counts 0..CLK_DIV-1, resets to 0 on every bit boundary, and is held at 0 in IDLE.
- The latched byte is immune to requester data or valid changes after acceptance.
- Requesters hold valid and data until ready. If valid drops before ready, nothing is sent and the arbiter has no side effects.
- A requester that is valid during a frame is not accepted and waits for IDLE.
- Reset asserted mid-frame:
  - io_uart_txd goes high immediately; the partial frame is abandoned.
  - The FSM goes to IDLE and grant_id = 1.
  - No ready pulses while reset is high.
- After reset deasserts, arbitration resumes on the first clock edge.
- grant_id changes only on an accept edge.

Test Plan:
1. CLK_DIV=4, STOP_BITS=1. Hold req0_valid with data 0x55 for one transfer.
   -> req0_ready pulses 1 cycle.
   -> txd is 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles.
   -> tx_busy is high for 40 cycles; grant_id = 0.
2. Both valid from reset, req0=0xA1, req1=0xB2, each held until accepted.
   -> Accept order is req0, req1, req0, ... strictly alternating.
   -> grant_id toggles 0,1,0.
   -> Accept edges are 41 cycles apart.
3. req1 valid alone with a continuous stream 0x00..0x03.
   -> All four bytes are sent on req1 with accept spacing of 41 cycles.
   -> req0_ready stays 0 throughout.
4. Start 0xFF on req0, then assert reset at cycle 20 of the frame for 2 cycles.
   -> txd = 1 in the same cycle as reset, tx_busy = 0, grant_id = 1.
   -> After release with both valid, req0 is granted first.
5. Change req0_data from 0x3C to 0xC3 during the frame.
   -> The serialised frame carries 0x3C; a frame for 0xC3 follows only after a new accept.
6. STOP_BITS=2, CLK_DIV=4, byte 0x80.
   -> The stop-high period is 8 cycles; tx_busy is high for 44 cycles; the accept-to-accept spacing is 45.
